// File: rtl/dest_reg_tracker_if.sv
// Bundle between the ID stage and the destination-register tracker: ID instruction
// fields going in; stall, forwarding selects and per-stage destinations coming back.
interface dest_reg_tracker_if;
   logic        id_valid;
   logic [4:0]  id_rd;
   logic        id_we;
   logic        id_ld;
   logic [4:0]  id_ra;
   logic [4:0]  id_rb;
   logic        id_ra_used;
   logic        id_rb_used;
   logic        flush;

   logic        stall;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [4:0]  ex_rd;
   logic [4:0]  mem_rd;
   logic [4:0]  wb_rd;
   logic        wb_we;
   logic [15:0] stall_cnt;

   modport master (
      output id_valid, id_rd, id_we, id_ld, id_ra, id_rb, id_ra_used, id_rb_used, flush,
      input  stall, fwd_a, fwd_b, ex_rd, mem_rd, wb_rd, wb_we, stall_cnt
   );

   modport slave (
      input  id_valid, id_rd, id_we, id_ld, id_ra, id_rb, id_ra_used, id_rb_used, flush,
      output stall, fwd_a, fwd_b, ex_rd, mem_rd, wb_rd, wb_we, stall_cnt
   );
endinterface

// File: rtl/dest_reg_tracker.sv
// Tracks the destination register of the EX/MEM/WB instructions and derives the
// load-use stall, the operand forwarding selects and a saturating stall counter.
module dest_reg_tracker #(
   parameter logic [15:0] STALL_CNT_MAX = 16'hFFFF
) (
   input logic               clk,
   input logic               rst_n,
   dest_reg_tracker_if.slave bus
);

   typedef struct packed {
      logic [4:0] rd;
      logic       we;
      logic       ld;
   } stage_t;

   stage_t      ex_q;
   stage_t      mem_q;
   stage_t      wb_q;
   stage_t      ex_d;
   logic        ex_live;
   logic        hazard_a;
   logic        hazard_b;
   logic        stall_int;
   logic [1:0]  fwd_a_int;
   logic [1:0]  fwd_b_int;
   logic [15:0] stall_cnt_q;

   // Youngest live writer wins; GR0 is never treated as a writer.
   function automatic logic [1:0] fwd_code(
      input logic [4:0] src,
      input logic       used,
      input logic       stall_now,
      input stage_t     ex,
      input stage_t     mem,
      input stage_t     wb
   );
      logic [1:0] code;
      code = 2'b00;
      if (used && !stall_now) begin
         if (ex.we && ex.rd != 5'd0 && ex.rd == src)
            code = 2'b01;
         else if (mem.we && mem.rd != 5'd0 && mem.rd == src)
            code = 2'b10;
         else if (wb.we && wb.rd != 5'd0 && wb.rd == src)
            code = 2'b11;
      end
      return code;
   endfunction

   always_comb begin
      ex_live   = ex_q.we && (ex_q.rd != 5'd0);
      hazard_a  = bus.id_ra_used && (bus.id_ra == ex_q.rd);
      hazard_b  = bus.id_rb_used && (bus.id_rb == ex_q.rd);
      stall_int = bus.id_valid && ex_q.ld && ex_live && (hazard_a || hazard_b);
      fwd_a_int = fwd_code(bus.id_ra, bus.id_ra_used, stall_int, ex_q, mem_q, wb_q);
      fwd_b_int = fwd_code(bus.id_rb, bus.id_rb_used, stall_int, ex_q, mem_q, wb_q);
   end

   // A stalled or flushed ID instruction leaves a bubble behind it in EX.
   always_comb begin
      ex_d = '0;
      if (bus.id_valid && !stall_int && !bus.flush) begin
         ex_d.rd = bus.id_rd;
         ex_d.we = bus.id_we;
         ex_d.ld = bus.id_ld;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= 16'd0;
      else if (stall_int && stall_cnt_q != STALL_CNT_MAX)
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign bus.stall     = stall_int;
   assign bus.fwd_a     = fwd_a_int;
   assign bus.fwd_b     = fwd_b_int;
   assign bus.ex_rd     = ex_q.rd;
   assign bus.mem_rd    = mem_q.rd;
   assign bus.wb_rd     = wb_q.rd;
   assign bus.wb_we     = wb_q.we && (wb_q.rd != 5'd0);
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed bench for dest_reg_tracker: forwarding, load-use stall, GR0, flush,
// counter saturation (small ceiling so it finishes quickly) and async reset.
module tb_dest_reg_tracker;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   dest_reg_tracker_if bus ();

   dest_reg_tracker #(.STALL_CNT_MAX(16'd30)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic valid, input logic [4:0] rd, input logic we, input logic ld,
                        input logic [4:0] ra, input logic ra_used, input logic [4:0] rb,
                        input logic rb_used, input logic fl);
      bus.id_valid   = valid;
      bus.id_rd      = rd;
      bus.id_we      = we;
      bus.id_ld      = ld;
      bus.id_ra      = ra;
      bus.id_ra_used = ra_used;
      bus.id_rb      = rb;
      bus.id_rb_used = rb_used;
      bus.flush      = fl;
      #1;
   endtask

   task automatic drain();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      drive(1, 5, 1, 1, 5, 1, 5, 1, 0);
      step();
      step();
      total_cnt++; if (bus.ex_rd !== 5'd0) $display("FAIL reset_ex_rd: got %0d expected 0", bus.ex_rd); else pass_cnt++;
      total_cnt++; if (bus.mem_rd !== 5'd0) $display("FAIL reset_mem_rd: got %0d expected 0", bus.mem_rd); else pass_cnt++;
      total_cnt++; if (bus.wb_rd !== 5'd0) $display("FAIL reset_wb_rd: got %0d expected 0", bus.wb_rd); else pass_cnt++;
      total_cnt++; if (bus.wb_we !== 1'b0) $display("FAIL reset_wb_we: got %0b expected 0", bus.wb_we); else pass_cnt++;
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %0b expected 0", bus.stall); else pass_cnt++;
      total_cnt++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) $display("FAIL reset_fwd: got a=%0b b=%0b expected 00/00", bus.fwd_a, bus.fwd_b); else pass_cnt++;
      total_cnt++; if (bus.stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cnt); else pass_cnt++;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 6, 1, 0, 5, 1, 0, 0, 0);
      total_cnt++; if (bus.fwd_a !== 2'b01) $display("FAIL b2b_fwd_a_ex: got %0b expected 01", bus.fwd_a); else pass_cnt++;
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL b2b_stall: got %0b expected 0", bus.stall); else pass_cnt++;
      total_cnt++; if (bus.fwd_b !== 2'b00) $display("FAIL b2b_fwd_b_unused: got %0b expected 00", bus.fwd_b); else pass_cnt++;
      step();
      drive(1, 0, 0, 0, 5, 1, 6, 1, 0);
      total_cnt++; if (bus.fwd_a !== 2'b10) $display("FAIL b2b_fwd_a_mem: got %0b expected 10", bus.fwd_a); else pass_cnt++;
      total_cnt++; if (bus.fwd_b !== 2'b01) $display("FAIL b2b_fwd_b_ex: got %0b expected 01", bus.fwd_b); else pass_cnt++;
      step();
      total_cnt++; if (bus.mem_rd !== 5'd6 || bus.wb_rd !== 5'd5) $display("FAIL b2b_latency: got mem=%0d wb=%0d expected 6/5", bus.mem_rd, bus.wb_rd); else pass_cnt++;
      total_cnt++; if (bus.wb_we !== 1'b1) $display("FAIL b2b_wb_we: got %0b expected 1", bus.wb_we); else pass_cnt++;
      total_cnt++; if (bus.fwd_a !== 2'b11 || bus.fwd_b !== 2'b10) $display("FAIL b2b_fwd_wb: got a=%0b b=%0b expected 11/10", bus.fwd_a, bus.fwd_b); else pass_cnt++;
      drain();
   endtask

   task automatic test_load_use();
      drive(1, 7, 1, 1, 0, 0, 0, 0, 0);
      step();
      drive(1, 8, 1, 0, 0, 0, 7, 1, 0);
      total_cnt++; if (bus.stall !== 1'b1) $display("FAIL lu_stall: got %0b expected 1", bus.stall); else pass_cnt++;
      total_cnt++; if (bus.fwd_b !== 2'b00) $display("FAIL lu_fwd_b_stalled: got %0b expected 00", bus.fwd_b); else pass_cnt++;
      step();
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL lu_stall_one_cycle: got %0b expected 0", bus.stall); else pass_cnt++;
      total_cnt++; if (bus.fwd_b !== 2'b10) $display("FAIL lu_fwd_b_mem: got %0b expected 10", bus.fwd_b); else pass_cnt++;
      total_cnt++; if (bus.ex_rd !== 5'd0) $display("FAIL lu_bubble: got %0d expected 0", bus.ex_rd); else pass_cnt++;
      total_cnt++; if (bus.stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt: got %0d expected 1", bus.stall_cnt); else pass_cnt++;
      step();
      total_cnt++; if (bus.ex_rd !== 5'd8 || bus.stall_cnt !== 16'd1) $display("FAIL lu_resume: got ex_rd=%0d cnt=%0d expected 8/1", bus.ex_rd, bus.stall_cnt); else pass_cnt++;
      drain();
   endtask

   task automatic test_priority_gr0();
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
      drive(1, 0, 0, 0, 3, 1, 0, 0, 0);
      total_cnt++; if (bus.fwd_a !== 2'b01) $display("FAIL prio_fwd_a: got %0b expected 01", bus.fwd_a); else pass_cnt++;
      drain();
      drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
      repeat (3) step();
      drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
      total_cnt++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) $display("FAIL gr0_fwd: got a=%0b b=%0b expected 00/00", bus.fwd_a, bus.fwd_b); else pass_cnt++;
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL gr0_stall: got %0b expected 0", bus.stall); else pass_cnt++;
      total_cnt++; if (bus.wb_we !== 1'b0) $display("FAIL gr0_wb_we: got %0b expected 0", bus.wb_we); else pass_cnt++;
      drain();
   endtask

   task automatic test_flush();
      drive(1, 9, 1, 0, 0, 0, 0, 0, 1);
      step();
      total_cnt++; if (bus.ex_rd !== 5'd0) $display("FAIL flush_ex_rd: got %0d expected 0", bus.ex_rd); else pass_cnt++;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      total_cnt++; if (bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd0) $display("FAIL flush_wb: got we=%0b rd=%0d expected 0/0", bus.wb_we, bus.wb_rd); else pass_cnt++;
      drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
      step();
      total_cnt++; if (bus.ex_rd !== 5'd9) $display("FAIL noflush_ex_rd: got %0d expected 9", bus.ex_rd); else pass_cnt++;
      drain();
      drive(1, 7, 1, 1, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 7, 1, 0);
      total_cnt++; if (bus.stall !== 1'b0 || bus.fwd_b !== 2'b01) $display("FAIL invalid_no_stall: got stall=%0b fwd_b=%0b expected 0/01", bus.stall, bus.fwd_b); else pass_cnt++;
      drive(1, 10, 1, 0, 0, 0, 7, 1, 1);
      total_cnt++; if (bus.stall !== 1'b1) $display("FAIL flush_stall: got %0b expected 1", bus.stall); else pass_cnt++;
      step();
      total_cnt++; if (bus.ex_rd !== 5'd0 || bus.stall_cnt !== 16'd2) $display("FAIL flush_stall_bubble: got ex_rd=%0d cnt=%0d expected 0/2", bus.ex_rd, bus.stall_cnt); else pass_cnt++;
      drain();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 40; i++) begin
         drive(1, 7, 1, 1, 0, 0, 0, 0, 0);
         step();
         drive(1, 0, 0, 0, 0, 0, 7, 1, 0);
         if (i == 39) begin
            total_cnt++; if (bus.stall !== 1'b1) $display("FAIL sat_stall: got %0b expected 1", bus.stall); else pass_cnt++;
         end
         step();
         if (i == 9) begin
            total_cnt++; if (bus.stall_cnt !== 16'd12) $display("FAIL sat_counting: got %0d expected 12", bus.stall_cnt); else pass_cnt++;
         end
      end
      total_cnt++; if (bus.stall_cnt !== 16'd30) $display("FAIL sat_hold: got %0d expected 30", bus.stall_cnt); else pass_cnt++;
      drain();
   endtask

   task automatic test_async_reset();
      drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 6, 1, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 4, 1, 5, 1, 0);
      total_cnt++; if (bus.ex_rd !== 5'd6 || bus.wb_rd !== 5'd4) $display("FAIL arst_pre: got ex=%0d wb=%0d expected 6/4", bus.ex_rd, bus.wb_rd); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (bus.ex_rd !== 5'd0 || bus.mem_rd !== 5'd0 || bus.wb_rd !== 5'd0) $display("FAIL arst_rd: got ex=%0d mem=%0d wb=%0d expected 0/0/0", bus.ex_rd, bus.mem_rd, bus.wb_rd); else pass_cnt++;
      total_cnt++; if (bus.wb_we !== 1'b0 || bus.stall_cnt !== 16'd0) $display("FAIL arst_we_cnt: got we=%0b cnt=%0d expected 0/0", bus.wb_we, bus.stall_cnt); else pass_cnt++;
      total_cnt++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) $display("FAIL arst_fwd: got a=%0b b=%0b expected 00/00", bus.fwd_a, bus.fwd_b); else pass_cnt++;
      step();
      #2 rst_n = 1'b1;
      drive(1, 11, 1, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total_cnt++; if (bus.ex_rd !== 5'd11) $display("FAIL arst_resume_ex: got %0d expected 11", bus.ex_rd); else pass_cnt++;
      step();
      step();
      total_cnt++; if (bus.wb_rd !== 5'd11 || bus.wb_we !== 1'b1) $display("FAIL arst_resume_wb: got rd=%0d we=%0b expected 11/1", bus.wb_rd, bus.wb_we); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n     = 1'b1;
      test_reset();
      test_back_to_back();
      test_load_use();
      test_priority_gr0();
      test_flush();
      test_saturation();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
